bu_arbiter: RTL and testbench
=============================

Name: bu_arbiter

Overview:
- Parametrised N-master AHB bus arbiter and mux. It connects the TLB bus unit, the L1 bus unit and external/DMA requesters to the single core AHB master port.
- Each requester holds the bus for as long as its req is asserted, using a req/ack handshake.
- Tracks the AHB data phase separately from the address phase, so hwdata follows the owner of the previous address phase and ownership changes never corrupt an in-flight beat.
- Fixed-priority arbitration by default; round-robin is a compile option.

Parameters:
- NM, 3, number of requesting masters (2..8); index 0 has the highest fixed priority.
- AW, 64, haddr width.
- DW, 64, hwdata/hrdata width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_bus_req  in  NM  per-master bus request; held high for the whole tenure
- m_bus_ack  out  NM  per-master grant, one-hot or zero
- m_haddr  in  NM*AW  per-master haddr, master i at slice [i*AW +: AW]
- m_hwrite  in  NM  per-master hwrite
- m_hsize  in  NM*4  per-master hsize
- m_hburst  in  NM*3  per-master hburst
- m_hprot  in  NM*4  per-master hprot
- m_htrans  in  NM*2  per-master htrans
- m_hmastlock  in  NM  per-master hmastlock
- m_hwdata  in  NM*DW  per-master hwdata
- m_hready  out  1  hready broadcast to all masters
- m_hresp  out  1  hresp broadcast to all masters
- m_hreset_n  out  1  hreset_n broadcast to all masters
- m_hrdata  out  DW  hrdata broadcast to all masters
- haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock  out  AW,1,4,3,4,2,1  muxed address-phase signals
- hwdata  out  DW  muxed data-phase write data
- hready, hresp, hreset_n  in  1 each  slave response
- hrdata  in  DW  slave read data

Behaviour:
- State machine: IDLE, GRANT, DRAIN. The owner index is registered as owner [clog2(NM)-1:0].
- Reset:
  - state=IDLE, owner=0, m_bus_ack=0.
  - Data-phase tracking cleared: dp_owner=0, dp_valid=0.
  - Round-robin pointer last=NM-1.
- IDLE:
  - If any m_bus_req is high, select a winner, set owner=winner, go to GRANT.
  - The winner's ack is high from the next cycle, so grant latency is 1 cycle from req.
- GRANT:
  - m_bus_ack[owner]=1.
  - When m_bus_req[owner]=0: ack drops in the next cycle.
  - The next state is IDLE if hready=1 in that cycle, otherwise DRAIN.
- DRAIN:
  - No ack is asserted.
  - Stay until hready=1, then go to IDLE.
- Turnaround: there is at least one IDLE cycle between two grants. Back-to-back handover is never allowed.
- Address-phase mux:
  - While ack is asserted, all address-phase outputs come from slice owner.
  - Otherwise htrans=2'b00, hmastlock=0, and the other address signals come from slice owner (don't-care values, kept stable).
- Data-phase tracking: on every cycle with hready=1:
  - dp_owner <= owner.
  - dp_valid <= (ack asserted) and (htrans[1]=1).
- hwdata = slice dp_owner of m_hwdata. It is not gated by dp_valid.
- Response signals (hready, hresp, hreset_n, hrdata) are passed through combinationally to all masters.
- A master must stop issuing NONSEQ/SEQ in the cycle its ack is low.
- Req dropping while hready=0 is legal and handled by DRAIN.
- Simultaneous requests in IDLE are resolved by the arbitration policy. Requests that arrive during GRANT/DRAIN wait.
- Reset mid-transfer returns to IDLE immediately and drops ack in the next cycle; no drain is performed.
- A request from an index >= NM cannot exist. The owner is never out of range.

Optional Feature:
- Macro BU_ARB_RR_EN.
- When defined: round-robin arbitration.
  - The search starts at index last+1, modulo NM.
  - last <= owner on each grant.
- When undefined: fixed priority, lowest requesting index wins. The last register is not implemented.

Test Plan:
- Reset, then req[1]=1 at cycle 2 -> ack=3'b010 at cycle 3; haddr equals the master 1 slice; other acks 0.
- req=3'b111 simultaneously:
  - Fixed priority -> grant order 0,1,2, each after its req drops, with one IDLE cycle between grants.
  - BU_ARB_RR_EN with last=0 -> grant order 1,2,0.
- Master 0 issues NONSEQ 0x8000_0000 write, then drops req with hready=0 for 3 cycles -> state DRAIN for 3 cycles, no ack, htrans=00, hwdata stays the master 0 slice until hready=1.
- Handover write: master 0 write data 0xAAAA then master 2 write data 0x5555 -> hwdata switches only one hready-cycle after master 2's first NONSEQ.
- No requests -> htrans=2'b00 and hmastlock=0 continuously; m_hrdata mirrors hrdata (0xDEAD_BEEF) to all masters.
- rst asserted during GRANT with hready=0 -> next cycle ack=0, state IDLE, dp_valid=0; a new req is granted one cycle after rst is released.

Source files
------------

// File: rtl/bu_arbiter.sv
// N-master AHB bus arbiter and mux: req/ack tenure per master, separate data-phase owner tracking.
// Compile option BU_ARB_RR_EN selects round-robin arbitration (default: fixed priority, index 0 highest).
module bu_arbiter #(
   parameter int NM = 3,
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM-1:0]    m_bus_req,
   output logic [NM-1:0]    m_bus_ack,
   input  logic [NM*AW-1:0] m_haddr,
   input  logic [NM-1:0]    m_hwrite,
   input  logic [NM*4-1:0]  m_hsize,
   input  logic [NM*3-1:0]  m_hburst,
   input  logic [NM*4-1:0]  m_hprot,
   input  logic [NM*2-1:0]  m_htrans,
   input  logic [NM-1:0]    m_hmastlock,
   input  logic [NM*DW-1:0] m_hwdata,
   output logic             m_hready,
   output logic             m_hresp,
   output logic             m_hreset_n,
   output logic [DW-1:0]    m_hrdata,
   output logic [AW-1:0]    haddr,
   output logic             hwrite,
   output logic [3:0]       hsize,
   output logic [2:0]       hburst,
   output logic [3:0]       hprot,
   output logic [1:0]       htrans,
   output logic             hmastlock,
   output logic [DW-1:0]    hwdata,
   input  logic             hready,
   input  logic             hresp,
   input  logic             hreset_n,
   input  logic [DW-1:0]    hrdata
);

   localparam int OW = (NM > 1) ? $clog2(NM) : 1;
   localparam logic [NM-1:0] ACK_LSB = NM'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_q;
   logic [OW-1:0] owner_q;
   logic [OW-1:0] dp_owner_q;
   logic          dp_valid_q;
   logic [NM-1:0] ack_q;
   logic [OW-1:0] winner;
   logic          ack_any;

   logic [AW-1:0] haddr_a     [NM];
   logic          hwrite_a    [NM];
   logic [3:0]    hsize_a     [NM];
   logic [2:0]    hburst_a    [NM];
   logic [3:0]    hprot_a     [NM];
   logic [1:0]    htrans_a    [NM];
   logic          hmastlock_a [NM];
   logic [DW-1:0] hwdata_a    [NM];

   for (genvar g = 0; g < NM; g++) begin : g_slice
      assign haddr_a[g]     = m_haddr[g*AW +: AW];
      assign hwrite_a[g]    = m_hwrite[g];
      assign hsize_a[g]     = m_hsize[g*4 +: 4];
      assign hburst_a[g]    = m_hburst[g*3 +: 3];
      assign hprot_a[g]     = m_hprot[g*4 +: 4];
      assign htrans_a[g]    = m_htrans[g*2 +: 2];
      assign hmastlock_a[g] = m_hmastlock[g];
      assign hwdata_a[g]    = m_hwdata[g*DW +: DW];
   end

   assign ack_any = |ack_q;

`ifdef BU_ARB_RR_EN
   logic [OW-1:0] last_q;
   logic          found;

   // Search begins just after the previous winner so every requester gets a turn.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NM; k++) begin
         if (!found && m_bus_req[(int'(last_q) + 1 + k) % NM]) begin
            winner = OW'((int'(last_q) + 1 + k) % NM);
            found  = 1'b1;
         end
      end
   end
`else
   always_comb begin
      winner = '0;
      for (int i = NM - 1; i >= 0; i--) begin
         if (m_bus_req[i]) winner = OW'(i);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         ack_q      <= '0;
         dp_owner_q <= '0;
         dp_valid_q <= 1'b0;
`ifdef BU_ARB_RR_EN
         last_q     <= OW'(NM - 1);
`endif
      end else begin
         // The data phase belongs to whoever owned the address phase just accepted.
         if (hready) begin
            dp_owner_q <= owner_q;
            dp_valid_q <= ack_any & htrans_a[owner_q][1];
         end
         case (state_q)
            IDLE: begin
               if (|m_bus_req) begin
                  owner_q <= winner;
                  ack_q   <= ACK_LSB << winner;
                  state_q <= GRANT;
`ifdef BU_ARB_RR_EN
                  last_q  <= winner;
`endif
               end
            end
            GRANT: begin
               if (!m_bus_req[owner_q]) begin
                  ack_q   <= '0;
                  state_q <= hready ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (hready) state_q <= IDLE;
            end
            default: begin
               ack_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Idle address phase keeps the owner's values stable but never issues a transfer.
   assign m_bus_ack = ack_q;
   assign haddr     = haddr_a[owner_q];
   assign hwrite    = hwrite_a[owner_q];
   assign hsize     = hsize_a[owner_q];
   assign hburst    = hburst_a[owner_q];
   assign hprot     = hprot_a[owner_q];
   assign htrans    = ack_any ? htrans_a[owner_q] : 2'b00;
   assign hmastlock = ack_any & hmastlock_a[owner_q];
   assign hwdata    = hwdata_a[dp_owner_q];

   assign m_hready   = hready;
   assign m_hresp    = hresp;
   assign m_hreset_n = hreset_n;
   assign m_hrdata   = hrdata;

   a_dp_owner_range: assert property (@(posedge clk) disable iff (rst)
      dp_valid_q |-> (int'(dp_owner_q) < NM));

endmodule

// File: tb/tb_bu_arbiter.sv
// Directed bench for bu_arbiter: vector table for arbitration order plus hand-written drain/handover/reset sequences.
module tb_bu_arbiter;
   localparam int NM = 3;
   localparam int AW = 64;
   localparam int DW = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    m_bus_req;
   logic [NM-1:0]    m_bus_ack;
   logic [NM*AW-1:0] m_haddr;
   logic [NM-1:0]    m_hwrite;
   logic [NM*4-1:0]  m_hsize;
   logic [NM*3-1:0]  m_hburst;
   logic [NM*4-1:0]  m_hprot;
   logic [NM*2-1:0]  m_htrans;
   logic [NM-1:0]    m_hmastlock;
   logic [NM*DW-1:0] m_hwdata;
   logic             m_hready, m_hresp, m_hreset_n;
   logic [DW-1:0]    m_hrdata;
   logic [AW-1:0]    haddr;
   logic             hwrite;
   logic [3:0]       hsize;
   logic [2:0]       hburst;
   logic [3:0]       hprot;
   logic [1:0]       htrans;
   logic             hmastlock;
   logic [DW-1:0]    hwdata;
   logic             hready, hresp, hreset_n;
   logic [DW-1:0]    hrdata;

   int n_checks = 0;
   int n_errors = 0;

   bu_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m_bus_req(m_bus_req), .m_bus_ack(m_bus_ack),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
      .m_hburst(m_hburst), .m_hprot(m_hprot), .m_htrans(m_htrans),
      .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
      .m_hready(m_hready), .m_hresp(m_hresp), .m_hreset_n(m_hreset_n),
      .m_hrdata(m_hrdata),
      .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
      .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hreset_n(hreset_n), .hrdata(hrdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] req;
      logic [2:0] ack;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] exp_addr;
      int          o;

`ifdef BU_ARB_RR_EN
      vecs[0] = '{3'b111, 3'b010};
      vecs[1] = '{3'b111, 3'b010};
      vecs[2] = '{3'b101, 3'b000};
      vecs[3] = '{3'b101, 3'b100};
      vecs[4] = '{3'b101, 3'b100};
      vecs[5] = '{3'b001, 3'b000};
      vecs[6] = '{3'b001, 3'b001};
      vecs[7] = '{3'b000, 3'b000};
      vecs[8] = '{3'b000, 3'b000};
`else
      vecs[0] = '{3'b111, 3'b001};
      vecs[1] = '{3'b111, 3'b001};
      vecs[2] = '{3'b110, 3'b000};
      vecs[3] = '{3'b110, 3'b010};
      vecs[4] = '{3'b110, 3'b010};
      vecs[5] = '{3'b100, 3'b000};
      vecs[6] = '{3'b100, 3'b100};
      vecs[7] = '{3'b000, 3'b000};
      vecs[8] = '{3'b000, 3'b000};
`endif

      rst = 1'b1;
      m_bus_req = '0;
      for (int i = 0; i < NM; i++) begin
         m_haddr[i*AW +: AW]  = 64'hA000_0000 + 64'(i) * 64'h100;
         m_hwdata[i*DW +: DW] = 64'h1111 * 64'(i + 1);
      end
      m_hwrite    = '1;
      m_hsize     = 12'h333;
      m_hburst    = '0;
      m_hprot     = 12'h333;
      m_htrans    = {3{2'b10}};
      m_hmastlock = '1;
      hready   = 1'b1;
      hresp    = 1'b0;
      hreset_n = 1'b1;
      hrdata   = '0;

      tick();
      tick();
      chk("reset_ack", 64'(m_bus_ack), 64'd0);
      chk("reset_htrans", 64'(htrans), 64'd0);
      chk("reset_hmastlock", 64'(hmastlock), 64'd0);
      chk("reset_state", 64'(dut.state_q), 64'd0);
      chk("reset_dp_valid", 64'(dut.dp_valid_q), 64'd0);
      chk("reset_hwdata", hwdata, 64'h1111);

      rst = 1'b0;
      tick();
      m_bus_req = 3'b010;
      #1;
      chk("grant1_before_edge", 64'(m_bus_ack), 64'd0);
      tick();
      chk("grant1_ack", 64'(m_bus_ack), 64'b010);
      chk("grant1_haddr", haddr, 64'hA000_0100);
      chk("grant1_htrans", 64'(htrans), 64'b10);
      chk("grant1_hmastlock", 64'(hmastlock), 64'd1);
      m_bus_req = 3'b000;
      tick();
      chk("release1_ack", 64'(m_bus_ack), 64'd0);

      m_bus_req = 3'b001;
      tick();
      chk("grant0_ack", 64'(m_bus_ack), 64'b001);
      m_bus_req = 3'b000;
      tick();
      chk("release0_ack", 64'(m_bus_ack), 64'd0);

      for (int v = 0; v < 9; v++) begin
         m_bus_req = vecs[v].req;
         tick();
         chk($sformatf("vec%0d_ack", v), 64'(m_bus_ack), 64'(vecs[v].ack));
         chk($sformatf("vec%0d_htrans", v), 64'(htrans), (vecs[v].ack != 3'b000) ? 64'b10 : 64'b00);
         if (vecs[v].ack != 3'b000) begin
            o = 0;
            for (int j = 0; j < NM; j++) if (vecs[v].ack[j]) o = j;
            exp_addr = 64'hA000_0000 + 64'(o) * 64'h100;
            chk($sformatf("vec%0d_haddr", v), haddr, exp_addr);
         end
      end

      // Quiet bus: no transfers, response mirrored to all masters
      hrdata = 64'hDEAD_BEEF;
      hresp  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("idle_htrans", 64'(htrans), 64'd0);
         chk("idle_hmastlock", 64'(hmastlock), 64'd0);
         chk("idle_hrdata", m_hrdata, 64'hDEAD_BEEF);
         chk("idle_hresp", 64'(m_hresp), 64'd1);
      end
      hready = 1'b0;
      hreset_n = 1'b0;
      #1;
      chk("pass_hready", 64'(m_hready), 64'd0);
      chk("pass_hreset_n", 64'(m_hreset_n), 64'd0);
      hready = 1'b1;
      hreset_n = 1'b1;
      hresp = 1'b0;

      // Drain and handover
      m_haddr[0 +: AW]      = 64'h8000_0000;
      m_hwdata[0 +: DW]     = 64'hAAAA;
      m_hwdata[2*DW +: DW]  = 64'h5555;
      m_bus_req = 3'b001;
      tick();
      chk("drain_grant_ack", 64'(m_bus_ack), 64'b001);
      chk("drain_grant_haddr", haddr, 64'h8000_0000);
      chk("drain_grant_hwrite", 64'(hwrite), 64'd1);
      tick();
      chk("m0_dp_valid", 64'(dut.dp_valid_q), 64'd1);
      chk("m0_hwdata", hwdata, 64'hAAAA);
      m_bus_req = 3'b100;
      hready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("drain%0d_state", c), 64'(dut.state_q), 64'd2);
         chk($sformatf("drain%0d_ack", c), 64'(m_bus_ack), 64'd0);
         chk($sformatf("drain%0d_htrans", c), 64'(htrans), 64'd0);
         chk($sformatf("drain%0d_hwdata", c), hwdata, 64'hAAAA);
      end
      hready = 1'b1;
      tick();
      chk("post_drain_state", 64'(dut.state_q), 64'd0);
      chk("post_drain_ack", 64'(m_bus_ack), 64'd0);
      chk("post_drain_dp_valid", 64'(dut.dp_valid_q), 64'd0);
      chk("post_drain_hwdata", hwdata, 64'hAAAA);
      tick();
      chk("m2_grant_ack", 64'(m_bus_ack), 64'b100);
      chk("m2_grant_htrans", 64'(htrans), 64'b10);
      chk("m2_first_hwdata", hwdata, 64'hAAAA);
      tick();
      chk("m2_hwdata", hwdata, 64'h5555);
      chk("m2_dp_valid", 64'(dut.dp_valid_q), 64'd1);

      // Reset during GRANT with a stalled slave
      hready = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst_grant_ack", 64'(m_bus_ack), 64'd0);
      chk("rst_grant_state", 64'(dut.state_q), 64'd0);
      chk("rst_grant_dp_valid", 64'(dut.dp_valid_q), 64'd0);
      rst = 1'b0;
      hready = 1'b1;
      #1;
      chk("rst_release_ack", 64'(m_bus_ack), 64'd0);
      tick();
      chk("rst_regrant_ack", 64'(m_bus_ack), 64'b100);
      m_bus_req = 3'b000;
      tick();
      chk("final_ack", 64'(m_bus_ack), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
